// File: rtl/chess_move_clock_if.sv
// ---------------------------------------------------------------------------
// chess_move_clock_if
//   Bundles the chess clock's game-control inputs and its display outputs.
//   master : the producer of Player/Checkmate/StartGame/Pause (layout matrix
//            side), which also observes the clock readouts.
//   slave  : the chess clock itself.
// Signals
//   Player        side to move, 1=white 0=black
//   Checkmate     [0]=king captured, [1]=capturing side (1=white)
//   StartGame     level, starts white's clock from IDLE
//   Pause         level, freezes the running clock
//   WhiteMinutes / WhiteSeconds, BlackMinutes / BlackSeconds  remaining time
//   ClockState    0=IDLE 1=RUN 2=PAUSE 3=OVER
//   Result        [0]=game over, [1]=winner (1=white)
//   Flagged       game ended on time rather than checkmate
// ---------------------------------------------------------------------------
interface chess_move_clock_if;
    logic       Player;
    logic [1:0] Checkmate;
    logic       StartGame;
    logic       Pause;
    logic [6:0] WhiteMinutes;
    logic [5:0] WhiteSeconds;
    logic [6:0] BlackMinutes;
    logic [5:0] BlackSeconds;
    logic [1:0] ClockState;
    logic [1:0] Result;
    logic       Flagged;

    modport master (
        output Player, Checkmate, StartGame, Pause,
        input  WhiteMinutes, WhiteSeconds, BlackMinutes, BlackSeconds,
        input  ClockState, Result, Flagged
    );

    modport slave (
        input  Player, Checkmate, StartGame, Pause,
        output WhiteMinutes, WhiteSeconds, BlackMinutes, BlackSeconds,
        output ClockState, Result, Flagged
    );
endinterface

// File: rtl/chess_move_clock.sv
// ---------------------------------------------------------------------------
// chess_move_clock
//   Two-player countdown chess clock. Keeps remaining minutes:seconds for
//   each side, runs the side named by Player, hands the clock over (with a
//   per-move increment for the side that just moved) whenever Player toggles,
//   and ends the game on checkmate or when the running side's time hits 0:00.
// Ports
//   OutClock  in  game clock, TICKS_PER_SEC cycles per second of game time
//   resetApp  in  asynchronous, active-high reset
//   bus       slave side of chess_move_clock_if (inputs from the layout
//             matrix, registered time/state/result outputs to the display)
// Parameters
//   TICKS_PER_SEC  OutClock cycles per game second (>=2)
//   START_MINUTES  starting minutes per player (1..99)
//   INCREMENT_SEC  seconds credited to the mover after each move (0..59)
// ---------------------------------------------------------------------------
module chess_move_clock #(
    parameter int TICKS_PER_SEC = 5,
    parameter int START_MINUTES = 10,
    parameter int INCREMENT_SEC = 0
) (
    input  logic              OutClock,
    input  logic              resetApp,
    chess_move_clock_if.slave bus
);

    localparam int TICK_W = $clog2(TICKS_PER_SEC);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);

    typedef struct packed {
        logic [6:0] mm;
        logic [5:0] ss;
    } clkTime_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } clockState_t;

    localparam clkTime_t START_TIME = {7'(START_MINUTES), 6'd0};

    // Adds the move increment with a single carry into minutes; anything that
    // would pass 99 minutes pins the display at 99:59.
    function automatic clkTime_t addIncrement(input clkTime_t t);
        logic [6:0] sum;
        clkTime_t   r;
        sum = {1'b0, t.ss} + 7'(INCREMENT_SEC);
        if (sum >= 7'd60) begin
            if (t.mm >= 7'd99) begin
                r.mm = 7'd99;
                r.ss = 6'd59;
            end else begin
                r.mm = t.mm + 7'd1;
                r.ss = 6'(sum - 7'd60);
            end
        end else begin
            r.mm = t.mm;
            r.ss = sum[5:0];
        end
        return r;
    endfunction

    // Removes one second with a borrow from minutes; 0:00 is a floor.
    function automatic clkTime_t takeSecond(input clkTime_t t);
        clkTime_t r;
        if (t.ss != 6'd0) begin
            r.mm = t.mm;
            r.ss = t.ss - 6'd1;
        end else if (t.mm != 7'd0) begin
            r.mm = t.mm - 7'd1;
            r.ss = 6'd59;
        end else begin
            r = t;
        end
        return r;
    endfunction

    clockState_t       state;
    logic [TICK_W-1:0] tickCnt;
    logic              prevPlayer;
    clkTime_t          whiteTime;
    clkTime_t          blackTime;
    logic [1:0]        result;
    logic              flagged;

    logic              toggle;
    clkTime_t          activeNext;
    clkTime_t          moverNext;
    logic              flagFall;

    // Next-value candidates: the running side after losing a second, and the
    // side that just moved after receiving its increment.
    always_comb begin
        toggle     = (bus.Player != prevPlayer);
        activeNext = takeSecond(bus.Player ? whiteTime : blackTime);
        moverNext  = addIncrement(prevPlayer ? whiteTime : blackTime);
        flagFall   = (activeNext == 13'd0);
    end

    // Clock state machine; every output is a register updated here.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            state      <= IDLE;
            tickCnt    <= '0;
            prevPlayer <= 1'b1;
            whiteTime  <= START_TIME;
            blackTime  <= START_TIME;
            result     <= 2'b00;
            flagged    <= 1'b0;
        end else begin
            prevPlayer <= bus.Player;
            case (state)
                IDLE: begin
                    if (bus.StartGame) begin
                        state   <= RUN;
                        tickCnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.Checkmate[0]) begin
                        state   <= OVER;
                        result  <= {bus.Checkmate[1], 1'b1};
                        flagged <= 1'b0;
                    end else if (toggle) begin
                        // Hand-over edge: credit the mover, restart the second,
                        // and skip any decrement that was due on this edge.
                        tickCnt <= '0;
                        if (prevPlayer) begin
                            whiteTime <= moverNext;
                        end else begin
                            blackTime <= moverNext;
                        end
                    end else if (bus.Pause) begin
                        state <= PAUSE;
                    end else if (tickCnt == TICK_MAX) begin
                        tickCnt <= '0;
                        if (bus.Player) begin
                            whiteTime <= activeNext;
                        end else begin
                            blackTime <= activeNext;
                        end
                        // Flag falls on the same edge that shows 0:00.
                        if (flagFall) begin
                            state   <= OVER;
                            result  <= {~bus.Player, 1'b1};
                            flagged <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                PAUSE: begin
                    if (bus.Checkmate[0]) begin
                        state   <= OVER;
                        result  <= {bus.Checkmate[1], 1'b1};
                        flagged <= 1'b0;
                    end else if (!bus.Pause) begin
                        state <= RUN;
                    end else begin
                        state <= PAUSE;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.WhiteMinutes = whiteTime.mm;
    assign bus.WhiteSeconds = whiteTime.ss;
    assign bus.BlackMinutes = blackTime.mm;
    assign bus.BlackSeconds = blackTime.ss;
    assign bus.ClockState   = state;
    assign bus.Result       = result;
    assign bus.Flagged      = flagged;

endmodule

// File: tb/tb_chess_move_clock.sv
// ---------------------------------------------------------------------------
// tb_chess_move_clock
//   Directed bench for chess_move_clock. Instance A: 5 ticks/s, 1 minute,
//   +2 s increment. Instance B: 5 ticks/s, 99 minutes, +59 s increment (for
//   increment saturation). Expected readouts are written as total seconds per
//   side, queued when stimulus is applied and compared after the edges.
// ---------------------------------------------------------------------------
module tb_chess_move_clock;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_OVER  = 3;

    typedef struct packed {
        logic [6:0] wm;
        logic [5:0] ws;
        logic [6:0] bm;
        logic [5:0] bs;
        logic [1:0] st;
        logic [1:0] res;
        logic       fl;
    } snap_t;

    typedef struct {
        string tag;
        bit    onB;
        snap_t s;
    } expect_t;

    logic OutClock = 1'b0;
    logic rstA;
    logic rstB;

    chess_move_clock_if ifA();
    chess_move_clock_if ifB();

    chess_move_clock #(.TICKS_PER_SEC(5), .START_MINUTES(1), .INCREMENT_SEC(2)) dutA (
        .OutClock(OutClock),
        .resetApp(rstA),
        .bus     (ifA)
    );

    chess_move_clock #(.TICKS_PER_SEC(5), .START_MINUTES(99), .INCREMENT_SEC(59)) dutB (
        .OutClock(OutClock),
        .resetApp(rstB),
        .bus     (ifB)
    );

    always #5 OutClock = ~OutClock;

    expect_t expQ[$];
    int      passCnt  = 0;
    int      checkCnt = 0;

    function automatic snap_t mk(input int wTot, input int bTot, input int st,
                                 input int res, input int fl);
        snap_t s;
        s.wm  = 7'(wTot / 60);
        s.ws  = 6'(wTot % 60);
        s.bm  = 7'(bTot / 60);
        s.bs  = 6'(bTot % 60);
        s.st  = 2'(st);
        s.res = 2'(res);
        s.fl  = 1'(fl);
        return s;
    endfunction

    function automatic snap_t obs(input bit onB);
        snap_t s;
        if (onB) begin
            s = {ifB.WhiteMinutes, ifB.WhiteSeconds, ifB.BlackMinutes, ifB.BlackSeconds,
                 ifB.ClockState, ifB.Result, ifB.Flagged};
        end else begin
            s = {ifA.WhiteMinutes, ifA.WhiteSeconds, ifA.BlackMinutes, ifA.BlackSeconds,
                 ifA.ClockState, ifA.Result, ifA.Flagged};
        end
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("W%0d:%02d B%0d:%02d state=%0d result=%b flagged=%b",
                         s.wm, s.ws, s.bm, s.bs, s.st, s.res, s.fl);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge OutClock);
        #1;
    endtask

    task automatic popCheck();
        expect_t e;
        snap_t   o;
        checkCnt++;
        if (expQ.size() == 0) begin
            $error("FAIL scoreboard: observed %s with no expected entry", fmt(obs(1'b0)));
        end else begin
            e = expQ.pop_front();
            o = obs(e.onB);
            assert (o === e.s) passCnt++;
            else $error("FAIL %s: observed %s expected %s", e.tag, fmt(o), fmt(e.s));
        end
    endtask

    // Queue the expectation, let n edges pass, then compare.
    task automatic expectAfter(input string tag, input bit onB, input int n, input snap_t s);
        expect_t e;
        e.tag = tag;
        e.onB = onB;
        e.s   = s;
        expQ.push_back(e);
        step(n);
        popCheck();
    endtask

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        ifA.Player = 1'b1; ifA.Checkmate = 2'b00; ifA.StartGame = 1'b0; ifA.Pause = 1'b0;
        ifB.Player = 1'b1; ifB.Checkmate = 2'b00; ifB.StartGame = 1'b0; ifB.Pause = 1'b0;
        #12;
        expectAfter("reset_state", 1'b0, 0, mk(60, 60, ST_IDLE, 0, 0));
        rstA = 1'b0;
        rstB = 1'b0;
        expectAfter("idle_hold", 1'b0, 2, mk(60, 60, ST_IDLE, 0, 0));
        ifA.Checkmate = 2'b11;
        expectAfter("idle_ignores_mate", 1'b0, 1, mk(60, 60, ST_IDLE, 0, 0));
        ifA.Checkmate = 2'b00;

        // White's clock: one second is five edges after entering RUN.
        ifA.StartGame = 1'b1;
        expectAfter("start_run", 1'b0, 1, mk(60, 60, ST_RUN, 0, 0));
        ifA.StartGame = 1'b0;
        expectAfter("white_tick4", 1'b0, 4, mk(60, 60, ST_RUN, 0, 0));
        expectAfter("white_borrow", 1'b0, 1, mk(59, 60, ST_RUN, 0, 0));
        expectAfter("white_057_tick4", 1'b0, 14, mk(57, 60, ST_RUN, 0, 0));

        // Hand-over at tick 4: +2 s to white, no decrement, black starts fresh.
        ifA.Player = 1'b0;
        expectAfter("toggle_increment", 1'b0, 1, mk(59, 60, ST_RUN, 0, 0));
        expectAfter("black_tick4", 1'b0, 4, mk(59, 60, ST_RUN, 0, 0));
        expectAfter("black_second", 1'b0, 1, mk(59, 59, ST_RUN, 0, 0));

        // Pause mid-second (tick 2) for 20 edges.
        expectAfter("black_mid", 1'b0, 2, mk(59, 59, ST_RUN, 0, 0));
        ifA.Pause = 1'b1;
        expectAfter("pause_enter", 1'b0, 1, mk(59, 59, ST_PAUSE, 0, 0));
        expectAfter("pause_held", 1'b0, 19, mk(59, 59, ST_PAUSE, 0, 0));
        ifA.Pause = 1'b0;
        expectAfter("resume", 1'b0, 1, mk(59, 59, ST_RUN, 0, 0));
        expectAfter("resume_tick4", 1'b0, 2, mk(59, 59, ST_RUN, 0, 0));
        expectAfter("resume_second", 1'b0, 1, mk(59, 58, ST_RUN, 0, 0));

        // Toggle while paused: no increment, white runs after resume.
        ifA.Pause = 1'b1;
        expectAfter("pause_again", 1'b0, 1, mk(59, 58, ST_PAUSE, 0, 0));
        ifA.Player = 1'b1;
        expectAfter("toggle_in_pause", 1'b0, 1, mk(59, 58, ST_PAUSE, 0, 0));
        ifA.Pause = 1'b0;
        expectAfter("resume_white", 1'b0, 1, mk(59, 58, ST_RUN, 0, 0));
        expectAfter("white_tick4_b", 1'b0, 4, mk(59, 58, ST_RUN, 0, 0));
        expectAfter("white_second_b", 1'b0, 1, mk(58, 58, ST_RUN, 0, 0));

        // Flag fall: 58 s left at tick 0.
        expectAfter("white_001", 1'b0, 289, mk(1, 58, ST_RUN, 0, 0));
        expectAfter("flag_fall", 1'b0, 1, mk(0, 58, ST_OVER, 1, 1));
        ifA.Player = 1'b0;
        ifA.Checkmate = 2'b11;
        expectAfter("over_hold", 1'b0, 10, mk(0, 58, ST_OVER, 1, 1));
        ifA.Checkmate = 2'b00;
        ifA.Player = 1'b1;

        // Reset from OVER, then checkmate on the edge the flag would fall.
        rstA = 1'b1;
        expectAfter("reset_from_over", 1'b0, 0, mk(60, 60, ST_IDLE, 0, 0));
        #2;
        rstA = 1'b0;
        step(1);
        ifA.StartGame = 1'b1;
        expectAfter("restart", 1'b0, 1, mk(60, 60, ST_RUN, 0, 0));
        ifA.StartGame = 1'b0;
        expectAfter("white_001_again", 1'b0, 299, mk(1, 60, ST_RUN, 0, 0));
        ifA.Checkmate = 2'b11;
        expectAfter("mate_beats_flag", 1'b0, 1, mk(1, 60, ST_OVER, 3, 0));
        ifA.Checkmate = 2'b00;
        expectAfter("mate_hold", 1'b0, 5, mk(1, 60, ST_OVER, 3, 0));

        // Asynchronous reset between edges while running.
        rstA = 1'b1;
        #2;
        rstA = 1'b0;
        step(1);
        ifA.StartGame = 1'b1;
        expectAfter("start_third", 1'b0, 1, mk(60, 60, ST_RUN, 0, 0));
        ifA.StartGame = 1'b0;
        expectAfter("run_seven", 1'b0, 7, mk(59, 60, ST_RUN, 0, 0));
        #2;
        rstA = 1'b1;
        expectAfter("async_reset", 1'b0, 0, mk(60, 60, ST_IDLE, 0, 0));
        expectAfter("reset_held", 1'b0, 1, mk(60, 60, ST_IDLE, 0, 0));
        rstA = 1'b0;

        // Instance B: 99-minute game with a 59 s increment.
        ifB.StartGame = 1'b1;
        expectAfter("b_start", 1'b1, 1, mk(5940, 5940, ST_RUN, 0, 0));
        ifB.StartGame = 1'b0;
        ifB.Player = 1'b0;
        expectAfter("b_white_inc", 1'b1, 1, mk(5999, 5940, ST_RUN, 0, 0));
        ifB.Player = 1'b1;
        expectAfter("b_black_inc", 1'b1, 1, mk(5999, 5999, ST_RUN, 0, 0));
        expectAfter("b_white_9930", 1'b1, 145, mk(5970, 5999, ST_RUN, 0, 0));
        ifB.Player = 1'b0;
        expectAfter("b_saturate", 1'b1, 1, mk(5999, 5999, ST_RUN, 0, 0));
        expectAfter("b_black_second", 1'b1, 5, mk(5999, 5998, ST_RUN, 0, 0));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
